// File: rtl/lsu_sram_master.sv
// Load/store unit master for a single-port SRAM with byte-lane masks.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two SRAM words.
module lsu_sram_master #(
    parameter int unsigned MAW = 14
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_req_valid,
    output logic           o_req_ready,
    input  logic [31:0]    i_req_addr,
    input  logic           i_req_we,
    input  logic [1:0]     i_req_size,
    input  logic           i_req_unsigned,
    input  logic [31:0]    i_req_wdata,
    output logic           o_rsp_valid,
    input  logic           i_rsp_ready,
    output logic [31:0]    o_rsp_rdata,
    output logic           o_rsp_err,
    output logic [MAW-1:0] o_sram_addr,
    output logic [31:0]    o_sram_wdata,
    output logic           o_sram_cs,
    output logic           o_sram_wren,
    output logic [3:0]     o_sram_bmask,
    input  logic [31:0]    i_sram_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle, StAcc0, StRd0, StAcc1, StRd1, StResp
    } state_t;

    state_t           state_q;
    logic [1:0]       off_q;
    logic [MAW-1:0]   waddr_q;
    logic             we_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [31:0]      wdata_q;
    logic [7:0]       mask_q;
    logic [31:0]      asm_q;

    logic [7:0]       req_mask8;
    logic             req_split;
    logic             req_bad;
    logic [31:0]      req_wdata_rot;
    logic             split_q;
    logic [3:0]       rd_lanes;
    logic [31:0]      asm_nxt;
    logic [31:0]      load_fmt;
    logic             unused_addr_hi;

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] rotl_bytes(input logic [31:0] w, input logic [1:0] off);
        logic [63:0] dbl;
        dbl = {w, w} << {off, 3'b000};
        return dbl[63:32];
    endfunction

    // Lanes from both words never overlap, so one rotate right realigns the whole value.
    function automatic logic [31:0] format_load(input logic [31:0] a, input logic [1:0] off,
                                                input logic [1:0] sz, input logic uns);
        logic [63:0] dbl;
        logic [31:0] r;
        dbl = {a, a} >> {off, 3'b000};
        r   = dbl[31:0];
        case (sz)
            2'b00:   r = {{24{r[7] & ~uns}}, r[7:0]};
            2'b01:   r = {{16{r[15] & ~uns}}, r[15:0]};
            default: r = r;
        endcase
        return r;
    endfunction

    assign unused_addr_hi = ^i_req_addr[31:MAW+2];

    assign req_mask8     = {4'b0000, size_mask(i_req_size)} << i_req_addr[1:0];
    assign req_split     = |req_mask8[7:4];
    assign req_bad       = (i_req_size == 2'b11) || (req_split && !SplitEn);
    assign req_wdata_rot = rotl_bytes(i_req_wdata, i_req_addr[1:0]);
    assign split_q       = |mask_q[7:4];
    assign rd_lanes      = (state_q == StRd1) ? mask_q[7:4] : mask_q[3:0];

    always_comb begin
        asm_nxt = asm_q;
        for (int i = 0; i < 4; i++) begin
            if (rd_lanes[i]) asm_nxt[8*i +: 8] = i_sram_rdata[8*i +: 8];
        end
    end

    assign load_fmt = format_load(asm_nxt, off_q, size_q, uns_q);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= StIdle;
            off_q        <= '0;
            waddr_q      <= '0;
            we_q         <= 1'b0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            mask_q       <= '0;
            asm_q        <= '0;
            o_req_ready  <= 1'b0;
            o_rsp_valid  <= 1'b0;
            o_rsp_rdata  <= '0;
            o_rsp_err    <= 1'b0;
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
            o_sram_cs    <= 1'b0;
            o_sram_wren  <= 1'b0;
            o_sram_bmask <= '0;
        end else begin
            o_sram_cs    <= 1'b0;
            o_sram_wren  <= 1'b0;
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
            o_sram_bmask <= '0;
            case (state_q)
                StIdle: begin
                    o_req_ready <= 1'b1;
                    if (i_req_valid && o_req_ready) begin
                        o_req_ready <= 1'b0;
                        off_q       <= i_req_addr[1:0];
                        waddr_q     <= i_req_addr[MAW+1:2];
                        we_q        <= i_req_we;
                        size_q      <= i_req_size;
                        uns_q       <= i_req_unsigned;
                        wdata_q     <= req_wdata_rot;
                        mask_q      <= req_mask8;
                        asm_q       <= '0;
                        if (req_bad) begin
                            state_q     <= StResp;
                            o_rsp_valid <= 1'b1;
                            o_rsp_err   <= 1'b1;
                            o_rsp_rdata <= '0;
                        end else begin
                            state_q      <= StAcc0;
                            o_sram_cs    <= 1'b1;
                            o_sram_wren  <= i_req_we;
                            o_sram_addr  <= i_req_addr[MAW+1:2];
                            o_sram_wdata <= req_wdata_rot;
                            o_sram_bmask <= req_mask8[3:0];
                        end
                    end
                end
                StAcc0: begin
                    if (!we_q) begin
                        state_q <= StRd0;
                    end else if (split_q) begin
                        state_q      <= StAcc1;
                        o_sram_cs    <= 1'b1;
                        o_sram_wren  <= 1'b1;
                        o_sram_addr  <= waddr_q + MAW'(1);
                        o_sram_wdata <= wdata_q;
                        o_sram_bmask <= mask_q[7:4];
                    end else begin
                        state_q     <= StResp;
                        o_rsp_valid <= 1'b1;
                    end
                end
                StRd0: begin
                    asm_q <= asm_nxt;
                    if (split_q) begin
                        state_q      <= StAcc1;
                        o_sram_cs    <= 1'b1;
                        o_sram_addr  <= waddr_q + MAW'(1);
                        o_sram_bmask <= mask_q[7:4];
                    end else begin
                        state_q     <= StResp;
                        o_rsp_valid <= 1'b1;
                        o_rsp_rdata <= load_fmt;
                    end
                end
                StAcc1: begin
                    if (we_q) begin
                        state_q     <= StResp;
                        o_rsp_valid <= 1'b1;
                    end else begin
                        state_q <= StRd1;
                    end
                end
                StRd1: begin
                    asm_q       <= asm_nxt;
                    state_q     <= StResp;
                    o_rsp_valid <= 1'b1;
                    o_rsp_rdata <= load_fmt;
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        state_q     <= StIdle;
                        o_rsp_valid <= 1'b0;
                        o_rsp_err   <= 1'b0;
                        o_rsp_rdata <= '0;
                        o_req_ready <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_sram_master.sv
// Self-checking bench for lsu_sram_master against a byte-array reference model.
// Honours LSU_MISALIGN_SPLIT_EN the same way the design does.
module tb_lsu_sram_master;

    localparam int MAW = 14;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [31:0]    req_addr = '0;
    logic           req_we = 1'b0;
    logic [1:0]     req_size = '0;
    logic           req_uns = 1'b0;
    logic [31:0]    req_wdata = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [31:0]    rsp_rdata;
    logic           rsp_err;
    logic [MAW-1:0] sram_addr;
    logic [31:0]    sram_wdata;
    logic           sram_cs;
    logic           sram_wren;
    logic [3:0]     sram_bmask;
    logic [31:0]    sram_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_sram_master #(.MAW(MAW)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_addr     (req_addr),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_uns),
        .i_req_wdata    (req_wdata),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_err      (rsp_err),
        .o_sram_addr    (sram_addr),
        .o_sram_wdata   (sram_wdata),
        .o_sram_cs      (sram_cs),
        .o_sram_wren    (sram_wren),
        .o_sram_bmask   (sram_bmask),
        .i_sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: unselected lanes of a read return garbage the DUT must ignore.
    bit [31:0] sram [0:(1<<MAW)-1];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_wren) begin
                for (int i = 0; i < 4; i++)
                    if (sram_bmask[i]) sram[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < 4; i++)
                    sram_rdata[8*i +: 8] <= sram_bmask[i] ? sram[sram_addr][8*i +: 8]
                                                          : 8'($urandom);
            end
        end
    end

    int             cs_cnt = 0;
    logic [MAW-1:0] log_addr  [64];
    logic [3:0]     log_mask  [64];
    logic           log_wren  [64];
    logic [31:0]    log_wdata [64];
    always @(posedge clk) begin
        if (sram_cs) begin
            log_addr[cs_cnt % 64]  <= sram_addr;
            log_mask[cs_cnt % 64]  <= sram_bmask;
            log_wren[cs_cnt % 64]  <= sram_wren;
            log_wdata[cs_cnt % 64] <= sram_wdata;
            cs_cnt <= cs_cnt + 1;
        end
    end

    // Reference model: flat byte memory covering the SRAM address space.
    bit [7:0] ref_mem [0:65535];

    task automatic ref_access(input logic [31:0] addr, input logic we, input logic [1:0] sz,
                              input logic uns, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err,
                              output int lat, output int ncs);
        int nb;
        bit mis;
        logic [15:0] ba;
        nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mis   = (int'(addr[1:0]) + nb) > 4;
        err   = (sz == 2'd3) || (mis && !SPLIT);
        rdata = '0;
        lat   = 1;
        ncs   = 0;
        if (!err) begin
            ncs = mis ? 2 : 1;
            lat = we ? (mis ? 3 : 2) : (mis ? 5 : 3);
            for (int i = 0; i < nb; i++) begin
                ba = addr[15:0] + 16'(i);
                if (we) ref_mem[ba] = wdata[8*i +: 8];
                else    rdata[8*i +: 8] = ref_mem[ba];
            end
            if (!we && !uns && nb < 4 && rdata[8*nb-1])
                for (int i = nb; i < 4; i++) rdata[8*i +: 8] = 8'hFF;
        end
    endtask

    // Drives one request, holds the response for 'hold' cycles, then accepts it.
    task automatic do_req(input logic [31:0] addr, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wdata, input int hold,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int ncs, output int base, output bit stable);
        int w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        req_addr  = addr;
        req_we    = we;
        req_size  = sz;
        req_uns   = uns;
        req_wdata = wdata;
        req_valid = 1'b1;
        base      = cs_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat       = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rdata  = rsp_rdata;
        err    = rsp_err;
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_rdata !== rdata || rsp_err !== err || req_ready)
                stable = 1'b0;
        end
        ncs = cs_cnt - base;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    int          lat, exp_lat, ncs, exp_ncs, base;
    bit          stable;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err, sram_cs, sram_wren, sram_bmask, rsp_rdata,
             sram_addr, sram_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got ready=%b valid=%b cs=%b exp all 0",
                               req_ready, rsp_valid, sram_cs);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready got %b exp 1", req_ready);
        end
    endtask

    task automatic test_aligned();
        do_req(32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 0, rd, er, lat, ncs, base, stable);
        n_checks++;
        if ({er, lat, ncs} !== {1'b0, 32'd2, 32'd1}) begin
            n_fail++; $display("FAIL sw_aligned err=%b lat=%0d ncs=%0d exp 0/2/1", er, lat, ncs);
        end
        n_checks++;
        if ({log_addr[base % 64], log_mask[base % 64], log_wren[base % 64],
             log_wdata[base % 64]} !== {14'd4, 4'hF, 1'b1, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL sw_aligned_sram addr=%0d mask=%h wren=%b wdata=%h exp 4/f/1/deadbeef",
                               log_addr[base % 64], log_mask[base % 64], log_wren[base % 64],
                               log_wdata[base % 64]);
        end
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL after_handshake valid=%b ready=%b exp 0/1", rsp_valid, req_ready);
        end
        do_req(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 0, rd, er, lat, ncs, base, stable);
        n_checks++;
        if ({rd, er, lat} !== {32'hDEADBEEF, 1'b0, 32'd3}) begin
            n_fail++; $display("FAIL lw_aligned data=%h err=%b lat=%0d exp deadbeef/0/3", rd, er, lat);
        end
    endtask

    task automatic test_sign_ext();
        do_req(32'h20, 1'b1, 2'd2, 1'b0, 32'h80FF7F01, 0, rd, er, lat, ncs, base, stable);
        do_req(32'h23, 1'b0, 2'd0, 1'b0, 32'h0, 0, rd, er, lat, ncs, base, stable);
        n_checks++;
        if ({rd, er} !== {32'hFFFFFF80, 1'b0}) begin
            n_fail++; $display("FAIL lb_sext got %h err=%b exp ffffff80", rd, er);
        end
        do_req(32'h23, 1'b0, 2'd0, 1'b1, 32'h0, 0, rd, er, lat, ncs, base, stable);
        n_checks++;
        if (rd !== 32'h00000080) begin
            n_fail++; $display("FAIL lbu got %h exp 00000080", rd);
        end
        do_req(32'h20, 1'b0, 2'd1, 1'b0, 32'h0, 0, rd, er, lat, ncs, base, stable);
        n_checks++;
        if ({rd, lat} !== {32'h00007F01, 32'd3}) begin
            n_fail++; $display("FAIL lh got %h lat=%0d exp 00007f01/3", rd, lat);
        end
    endtask

    task automatic test_backpressure();
        do_req(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 4, rd, er, lat, ncs, base, stable);
        n_checks++;
        if ({stable, rd} !== {1'b1, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL backpressure stable=%b data=%h exp 1/deadbeef", stable, rd);
        end
        do_req(32'h10, 1'b0, 2'd3, 1'b0, 32'h0, 0, rd, er, lat, ncs, base, stable);
        n_checks++;
        if ({rd, er, lat, ncs} !== {32'h0, 1'b1, 32'd1, 32'd0}) begin
            n_fail++; $display("FAIL illegal_size data=%h err=%b lat=%0d ncs=%0d exp 0/1/1/0",
                               rd, er, lat, ncs);
        end
    endtask

    task automatic test_reset_mid();
        bit quiet = 1'b1;
        req_addr = 32'h10; req_we = 1'b0; req_size = 2'd2; req_uns = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({sram_cs, rsp_valid, req_ready} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid_outputs cs=%b valid=%b ready=%b exp 000",
                               sram_cs, rsp_valid, req_ready);
        end
        base = cs_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid) quiet = 1'b0;
        end
        n_checks++;
        if ({quiet, cs_cnt - base, req_ready} !== {1'b1, 32'd0, 1'b1}) begin
            n_fail++; $display("FAIL reset_mid_abort quiet=%b extra_cs=%0d ready=%b exp 1/0/1",
                               quiet, cs_cnt - base, req_ready);
        end
        do_req(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, 0, rd, er, lat, ncs, base, stable);
        n_checks++;
        if ({rd, er, lat} !== {32'hDEADBEEF, 1'b0, 32'd3}) begin
            n_fail++; $display("FAIL reset_mid_reload data=%h err=%b lat=%0d exp deadbeef/0/3",
                               rd, er, lat);
        end
    endtask

    task automatic test_split();
        ref_access(32'h0E, 1'b1, 2'd2, 1'b0, 32'h11223344, exp_rd, exp_er, exp_lat, exp_ncs);
        do_req(32'h0E, 1'b1, 2'd2, 1'b0, 32'h11223344, 0, rd, er, lat, ncs, base, stable);
        n_checks++;
        if ({er, lat, ncs} !== {exp_er, exp_lat, exp_ncs}) begin
            n_fail++; $display("FAIL sw_split err=%b lat=%0d ncs=%0d exp %b/%0d/%0d",
                               er, lat, ncs, exp_er, exp_lat, exp_ncs);
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        n_checks++;
        if ({log_addr[base % 64], log_mask[base % 64], log_wdata[base % 64],
             log_addr[(base + 1) % 64], log_mask[(base + 1) % 64]}
            !== {14'd3, 4'hC, 32'h33441122, 14'd4, 4'h3}) begin
            n_fail++; $display("FAIL sw_split_sram a0=%0d m0=%h d0=%h a1=%0d m1=%h exp 3/c/33441122/4/3",
                               log_addr[base % 64], log_mask[base % 64], log_wdata[base % 64],
                               log_addr[(base + 1) % 64], log_mask[(base + 1) % 64]);
        end
`endif
        ref_access(32'h0E, 1'b0, 2'd2, 1'b0, 32'h0, exp_rd, exp_er, exp_lat, exp_ncs);
        do_req(32'h0E, 1'b0, 2'd2, 1'b0, 32'h0, 0, rd, er, lat, ncs, base, stable);
        n_checks++;
        if ({rd, er, lat, ncs} !== {exp_rd, exp_er, exp_lat, exp_ncs}) begin
            n_fail++; $display("FAIL lw_split data=%h err=%b lat=%0d ncs=%0d exp %h/%b/%0d/%0d",
                               rd, er, lat, ncs, exp_rd, exp_er, exp_lat, exp_ncs);
        end
    endtask

    task automatic test_wrap();
        ref_access(32'hFFFE, 1'b1, 2'd2, 1'b0, 32'hA5B6C7D8, exp_rd, exp_er, exp_lat, exp_ncs);
        do_req(32'hFFFE, 1'b1, 2'd2, 1'b0, 32'hA5B6C7D8, 0, rd, er, lat, ncs, base, stable);
        n_checks++;
        if ({er, lat, ncs} !== {exp_er, exp_lat, exp_ncs}) begin
            n_fail++; $display("FAIL sw_wrap err=%b lat=%0d ncs=%0d exp %b/%0d/%0d",
                               er, lat, ncs, exp_er, exp_lat, exp_ncs);
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        n_checks++;
        if ({log_addr[base % 64], log_addr[(base + 1) % 64]} !== {14'h3FFF, 14'd0}) begin
            n_fail++; $display("FAIL sw_wrap_addr a0=%h a1=%h exp 3fff/0",
                               log_addr[base % 64], log_addr[(base + 1) % 64]);
        end
`endif
        ref_access(32'hFFFE, 1'b0, 2'd2, 1'b0, 32'h0, exp_rd, exp_er, exp_lat, exp_ncs);
        do_req(32'hFFFE, 1'b0, 2'd2, 1'b0, 32'h0, 0, rd, er, lat, ncs, base, stable);
        n_checks++;
        if ({rd, er, lat, ncs} !== {exp_rd, exp_er, exp_lat, exp_ncs}) begin
            n_fail++; $display("FAIL lw_wrap data=%h err=%b lat=%0d ncs=%0d exp %h/%b/%0d/%0d",
                               rd, er, lat, ncs, exp_rd, exp_er, exp_lat, exp_ncs);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, wd;
        logic        we, uns;
        logic [1:0]  sz;
        for (int i = 0; i < 76; i++) begin
            if (i < 16) begin
                a = 32'h100 + 32'(4 * i); we = 1'b1; sz = 2'd2; uns = 1'b0;
            end else begin
                a   = 32'h100 + 32'($urandom_range(0, 59));
                we  = 1'($urandom);
                sz  = 2'($urandom);
                uns = 1'($urandom);
            end
            wd = $urandom;
            ref_access(a, we, sz, uns, wd, exp_rd, exp_er, exp_lat, exp_ncs);
            do_req(a, we, sz, uns, wd, int'($urandom_range(0, 2)), rd, er, lat, ncs, base, stable);
            n_checks++;
            if (rd !== exp_rd) begin
                n_fail++; $display("FAIL rand_data op=%0d addr=%h we=%b sz=%0d got %h exp %h",
                                   i, a, we, sz, rd, exp_rd);
            end
            n_checks++;
            if (er !== exp_er) begin
                n_fail++; $display("FAIL rand_err op=%0d addr=%h sz=%0d got %b exp %b",
                                   i, a, sz, er, exp_er);
            end
            n_checks++;
            if (lat !== exp_lat) begin
                n_fail++; $display("FAIL rand_lat op=%0d addr=%h we=%b sz=%0d got %0d exp %0d",
                                   i, a, we, sz, lat, exp_lat);
            end
            n_checks++;
            if (ncs !== exp_ncs) begin
                n_fail++; $display("FAIL rand_cs op=%0d addr=%h sz=%0d got %0d exp %0d",
                                   i, a, sz, ncs, exp_ncs);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_aligned();
        test_sign_ext();
        test_backpressure();
        test_reset_mid();
        test_split();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
